// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: command handshake and DataMemory bus of the copy/fill engine
interface mem_copy_engine_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   logic                  start;
   logic                  mode;
   logic [ADDR_WIDTH-1:0] src;
   logic [ADDR_WIDTH-1:0] dst;
   logic [LEN_WIDTH-1:0]  len;
   logic [DATA_WIDTH-1:0] fill_val;
   logic [DATA_WIDTH-1:0] mem_rd;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic                  mem_we;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [15:0]           checksum;
   modport master (
      input  start, mode, src, dst, len, fill_val, mem_rd,
      output mem_addr, mem_wd, mem_we, busy, done, err, checksum
   );
   modport slave (
      output start, mode, src, dst, len, fill_val, mem_rd,
      input  mem_addr, mem_wd, mem_we, busy, done, err, checksum
   );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block COPY/FILL initiator for the single-port DataMemory; MEMCPY_CHECKSUM_EN adds a written-word checksum.
module mem_copy_engine #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int MEM_DEPTH  = 100
) (
   input  logic                 CLK,
   input  logic                 RST,
   mem_copy_engine_if.master    bus
);
   typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, FINISH} state_t;
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [LEN_WIDTH-1:0]  len_q, idx_q;
   logic [DATA_WIDTH-1:0] fill_q, hold_q, wd;
   logic                  err_q, we, accept, range_err, last;
   logic [ADDR_WIDTH:0]   src_end, dst_end;
   // end-of-range sums carry one extra bit so a wrapping base is still rejected
   assign src_end   = {1'b0, bus.src} + (ADDR_WIDTH+1)'(bus.len);
   assign dst_end   = {1'b0, bus.dst} + (ADDR_WIDTH+1)'(bus.len);
   assign range_err = dst_end > DEPTH || (!bus.mode && src_end > DEPTH);
   assign accept    = state_q == IDLE && bus.start;
   assign last      = idx_q == len_q - LEN_WIDTH'(1);
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = (range_err || bus.len == '0) ? FINISH : bus.mode ? FILL : READ;
         READ:    state_d = WRITE;
         WRITE:   state_d = last ? FINISH : READ;
         FILL:    state_d = last ? FINISH : FILL;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      we           = state_q == WRITE || state_q == FILL;
      wd           = state_q == WRITE ? hold_q : state_q == FILL ? fill_q : '0;
      bus.mem_we   = we;
      bus.mem_wd   = wd;
      bus.mem_addr = state_q == READ ? src_q + ADDR_WIDTH'(idx_q) : we ? dst_q + ADDR_WIDTH'(idx_q) : '0;
      bus.busy     = we || state_q == READ;
      bus.done     = state_q == FINISH;
      bus.err      = state_q == FINISH && err_q;
   end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            src_q  <= bus.src;
            dst_q  <= bus.dst;
            len_q  <= bus.len;
            fill_q <= bus.fill_val;
            err_q  <= range_err;
            idx_q  <= '0;
         end else if (we) idx_q <= idx_q + LEN_WIDTH'(1);
         if (state_q == READ) hold_q <= bus.mem_rd;
      end
   end
`ifdef MEMCPY_CHECKSUM_EN
   logic [15:0] csum_q;
   always_ff @(posedge CLK) begin
      if (!RST) csum_q <= '0;
      else if (accept) csum_q <= '0;
      else if (we) csum_q <= csum_q + wd[15:0];
   end
   assign bus.checksum = csum_q;
`else
   assign bus.checksum = 16'd0;
`endif
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: table vectors, hand-written corner sequences and random commands against a word-level memory model.
module tb_mem_copy_engine;
   localparam int AW = 32, DW = 32, LW = 8, DEPTH = 100;
`ifdef MEMCPY_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif
   typedef struct {
      logic          mode;
      logic [31:0]   src, dst;
      logic [7:0]    len;
      logic [31:0]   fill;
      logic          tab;
      int            exp_done;
      logic          exp_err;
      logic          chk_cs;
      logic [15:0]   exp_cs;
   } vec_t;
   typedef struct {logic [31:0] a; logic [31:0] d; int c;} wr_t;
   logic CLK = 1'b0, RST = 1'b0;
   always #5 CLK = ~CLK;
   mem_copy_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();
   mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MEM_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .bus(bus));
   logic [DW-1:0] mem    [DEPTH];
   logic [DW-1:0] refmem [DEPTH];
   logic          init_req = 1'b0, poke_en = 1'b0;
   logic [6:0]    poke_a = '0;
   logic [DW-1:0] poke_d = '0;
   always @(posedge CLK)
      if (init_req) for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
      else if (bus.mem_we && bus.mem_addr < DEPTH) mem[bus.mem_addr[6:0]] <= bus.mem_wd;
      else if (poke_en) mem[poke_a] <= poke_d;
   assign bus.mem_rd = bus.mem_addr < DEPTH ? mem[bus.mem_addr[6:0]] : '0;
   int  checks = 0, failures = 0;
   wr_t act_q[$], exp_q[$];
   vec_t vecs[10];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic init_mem();
      init_req = 1'b1;
      @(negedge CLK);
      init_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) refmem[i] = mem[i];
   endtask
   task automatic poke(input logic [6:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_a = a; poke_d = d;
      @(negedge CLK);
      poke_en = 1'b0;
      refmem[a] = d;
   endtask
   task automatic mem_cmp(input string name);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== refmem[i]) bad++;
      check({name, " mem"}, 64'(bad), 64'(0));
   endtask
   // Word-level reference: range rule, ascending word copy and the cycle each write should land on
   task automatic model(input vec_t v, output int exp_done, output logic exp_err, output int exp_busy,
                        output logic [15:0] exp_cs);
      logic [32:0] de, se;
      logic [31:0] d;
      int n = int'(v.len);
      exp_q.delete();
      exp_cs = 16'd0; exp_busy = 0; exp_done = 1;
      de = {1'b0, v.dst} + 33'(v.len);
      se = {1'b0, v.src} + 33'(v.len);
      exp_err = de > 33'(DEPTH) || (!v.mode && se > 33'(DEPTH));
      if (exp_err || n == 0) return;
      for (int i = 0; i < n; i++) begin
         d = v.mode ? v.fill : refmem[v.src + 32'(i)];
         refmem[v.dst + 32'(i)] = d;
         exp_q.push_back('{v.dst + 32'(i), d, v.mode ? i + 1 : 2 * i + 2});
         exp_cs += d[15:0];
      end
      exp_busy = v.mode ? n : 2 * n;
      exp_done = exp_busy + 1;
      if (!CS_EN) exp_cs = 16'd0;
   endtask
   task automatic run_cmd(input vec_t v, output int done_cyc, output logic err_o, output int busy_n,
                          output logic [15:0] cs);
      act_q.delete();
      busy_n = 0; done_cyc = -1; err_o = 1'b0; cs = 16'd0;
      bus.start = 1'b1; bus.mode = v.mode; bus.src = v.src; bus.dst = v.dst;
      bus.len = v.len; bus.fill_val = v.fill;
      @(posedge CLK);
      for (int k = 1; k <= 700; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            bus.start = 1'b0; bus.mode = 1'($urandom); bus.src = $urandom; bus.dst = $urandom;
            bus.len = 8'($urandom); bus.fill_val = $urandom;
         end
         if (bus.mem_we) act_q.push_back('{bus.mem_addr, bus.mem_wd, k});
         if (bus.busy) busy_n++;
         if (bus.done) begin
            done_cyc = k; err_o = bus.err; cs = bus.checksum;
            break;
         end
      end
   endtask
   task automatic exec_vec(input vec_t v, input string name);
      int ed, eb, ad, ab;
      logic ee, ae;
      logic [15:0] ecs, acs;
      model(v, ed, ee, eb, ecs);
      run_cmd(v, ad, ae, ab, acs);
      check({name, " done_cycle"}, 64'(ad), 64'(ed));
      check({name, " err"}, 64'(ae), 64'(ee));
      check({name, " busy_cycles"}, 64'(ab), 64'(eb));
      check({name, " checksum"}, 64'(acs), 64'(ecs));
      check({name, " write_count"}, 64'(act_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         check({name, " write_addr_data"}, {act_q[i].a, act_q[i].d}, {exp_q[i].a, exp_q[i].d});
         check({name, " write_cycle"}, 64'(act_q[i].c), 64'(exp_q[i].c));
      end
      if (v.tab) begin
         check({name, " table_done"}, 64'(ad), 64'(v.exp_done));
         check({name, " table_err"}, 64'(ae), 64'(v.exp_err));
         if (v.chk_cs) check({name, " table_checksum"}, 64'(acs), 64'(CS_EN ? v.exp_cs : 16'd0));
      end
      @(negedge CLK);
      mem_cmp(name);
   endtask
   initial begin
      vec_t v;
      int   done_seen;
      bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
      vecs[0] = '{1'b1, 32'd0,  32'd10, 8'd4,   32'hA5A5_0001, 1'b1, 5,   1'b0, 1'b1, 16'h0004};
      vecs[1] = '{1'b0, 32'd0,  32'd20, 8'd3,   32'd0,         1'b1, 7,   1'b0, 1'b1, 16'h0006};
      vecs[2] = '{1'b0, 32'd5,  32'd5,  8'd0,   32'd0,         1'b1, 1,   1'b0, 1'b1, 16'h0000};
      vecs[3] = '{1'b1, 32'd0,  32'd98, 8'd3,   32'h0000_1234, 1'b1, 1,   1'b1, 1'b1, 16'h0000};
      vecs[4] = '{1'b1, 32'd0,  32'd97, 8'd3,   32'h0000_0010, 1'b1, 4,   1'b0, 1'b1, 16'h0030};
      vecs[5] = '{1'b0, 32'd95, 32'd0,  8'd6,   32'd0,         1'b1, 1,   1'b1, 1'b1, 16'h0000};
      vecs[6] = '{1'b0, 32'd40, 32'd41, 8'd4,   32'd0,         1'b1, 9,   1'b0, 1'b0, 16'h0000};
      vecs[7] = '{1'b1, 32'd0,  32'd0,  8'd100, 32'h0000_FFFF, 1'b1, 101, 1'b0, 1'b1, 16'hFF9C};
      vecs[8] = '{1'b1, 32'd0,  32'd0,  8'd101, 32'h0000_0005, 1'b1, 1,   1'b1, 1'b1, 16'h0000};
      vecs[9] = '{1'b1, 32'd0,  32'hFFFF_FFFF, 8'd2, 32'h7,    1'b1, 1,   1'b1, 1'b1, 16'h0000};
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      init_mem();
      poke(7'd0, 32'd1); poke(7'd1, 32'd2); poke(7'd2, 32'd3);
      for (int i = 0; i < 10; i++) exec_vec(vecs[i], $sformatf("vec%0d", i));
      init_mem();
      // COPY LEN=0: START held through FINISH is ignored, accepted once back in IDLE
      bus.start = 1'b1; bus.mode = 1'b0; bus.src = 32'd5; bus.dst = 32'd5; bus.len = 8'd0;
      @(posedge CLK); @(negedge CLK);
      check("len0 done", 64'(bus.done), 64'(1));
      check("len0 err", 64'(bus.err), 64'(0));
      check("len0 we", 64'(bus.mem_we), 64'(0));
      bus.mode = 1'b1; bus.dst = 32'd50; bus.len = 8'd1; bus.fill_val = 32'hC0DE_0050;
      @(negedge CLK);
      check("finish start ignored busy", 64'(bus.busy), 64'(0));
      check("finish start ignored done", 64'(bus.done), 64'(0));
      @(negedge CLK);
      bus.start = 1'b0;
      check("idle start accepted we", 64'(bus.mem_we), 64'(1));
      check("idle start accepted addr", 64'(bus.mem_addr), 64'(50));
      check("idle start accepted wd", 64'(bus.mem_wd), 64'(32'hC0DE_0050));
      @(negedge CLK);
      check("idle start done", 64'(bus.done), 64'(1));
      refmem[50] = 32'hC0DE_0050;
      @(negedge CLK);
      mem_cmp("len0 seq");
      // COPY LEN=5 interrupted by reset during its second write
      bus.start = 1'b1; bus.mode = 1'b0; bus.src = 32'd30; bus.dst = 32'd60; bus.len = 8'd5;
      @(posedge CLK);
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLK);
         bus.start = 1'b1; bus.mode = 1'b1; bus.dst = 32'd80; bus.len = 8'd3; bus.fill_val = 32'hDEAD_0000;
      end
      @(negedge CLK);
      bus.start = 1'b0;
      check("abort second write addr", 64'(bus.mem_addr), 64'(61));
      check("abort second write we", 64'(bus.mem_we), 64'(1));
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      check("abort busy", 64'(bus.busy), 64'(0));
      check("abort done", 64'(bus.done), 64'(0));
      check("abort we", 64'(bus.mem_we), 64'(0));
      check("abort addr", 64'(bus.mem_addr), 64'(0));
      done_seen = 0;
      repeat (6) begin
         @(negedge CLK);
         if (bus.done || bus.busy) done_seen++;
      end
      check("abort quiet", 64'(done_seen), 64'(0));
      refmem[60] = refmem[30]; refmem[61] = refmem[31];
      mem_cmp("abort");
      for (int i = 0; i < 16; i++) begin
         v = '{1'($urandom), 32'($urandom_range(0, 104)), 32'($urandom_range(0, 104)),
               8'($urandom_range(0, 12)), $urandom, 1'b0, 0, 1'b0, 1'b0, 16'h0};
         exec_vec(v, $sformatf("rnd%0d", i));
      end
      v = '{1'b1, 32'd0, 32'd70, 8'd2, 32'h0000_0003, 1'b0, 0, 1'b0, 1'b0, 16'h0};
      exec_vec(v, "pre_reset fill");
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      check("idle reset we", 64'(bus.mem_we), 64'(0));
      check("idle reset busy", 64'(bus.busy), 64'(0));
      check("idle reset done", 64'(bus.done), 64'(0));
      check("idle reset err", 64'(bus.err), 64'(0));
      check("idle reset addr", 64'(bus.mem_addr), 64'(0));
      check("idle reset checksum", 64'(bus.checksum), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
